nonce_scanner: RTL and testbench

- Job-side initiator for the doublesha engine.
- Takes a 640-bit block header template, a nonce range and a 256-bit target.
- For each nonce in the range it issues one header to doublesha and waits for its hash. It then compares the hash against the target.
- Stops on the first winning nonce, on range exhaustion, on abort, or on engine timeout. Sits between the host job registers and one doublesha instance.

---
 rtl/nonce_scanner_pkg.sv | 33 +++
 rtl/nonce_scanner_hash_target_cmp.sv | 26 ++
 rtl/nonce_scanner.sv | 191 +++++++++++++++++++
 tb/tb_nonce_scanner.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nonce_scanner_pkg.sv
// Shared types, widths and byte-order helpers for the nonce scanner
// and the engine-dispatch logic that reuses its pieces.
package nonce_scanner_pkg;

    localparam int HEADER_W = 640;
    localparam int HASH_W   = 256;
    localparam int NONCE_W  = 32;

    // Explicit encodings keep the state values stable for external debug taps.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // The nonce travels little-endian inside the header.
    function automatic logic [NONCE_W-1:0] byteswap32(input logic [NONCE_W-1:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    // Full digest byte reversal (SHA output order to numeric order).
    function automatic logic [HASH_W-1:0] byteswap256(input logic [HASH_W-1:0] v);
        logic [HASH_W-1:0] r;
        r = '0;
        for (int i = 0; i < HASH_W / 8; i++) begin
            r[8*i +: 8] = v[8*(HASH_W/8-1-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/nonce_scanner_hash_target_cmp.sv
// Combinational digest-versus-target test: optional byte reversal of the
// digest followed by an unsigned less-than-or-equal compare.
module hash_target_cmp
    import nonce_scanner_pkg::*;
#(
    parameter bit REVERSE = 1'b1
) (
    input  logic [HASH_W-1:0] hash,
    input  logic [HASH_W-1:0] target,
    output logic              win
);

    logic [HASH_W-1:0] swapped;
    logic [HASH_W-1:0] cmp_val;

    // Byte lane gi of the compare value comes from the mirrored digest lane.
    generate
        for (genvar gi = 0; gi < HASH_W / 8; gi++) begin : g_rev
            assign swapped[8*gi +: 8] = hash[8*(HASH_W/8-1-gi) +: 8];
        end
    endgenerate

    assign cmp_val = REVERSE ? swapped : hash;
    assign win     = (cmp_val <= target);

endmodule

// File: rtl/nonce_scanner.sv
// Job-side initiator for one doublesha engine: walks a nonce range, issues
// one header per nonce, checks each digest against the target and stops on
// win, exhaustion, abort or engine timeout.
module nonce_scanner
    import nonce_scanner_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter bit HASH_REVERSE   = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [HEADER_W-1:0] header_i,
    input  logic [NONCE_W-1:0]  nonce_first_i,
    input  logic [NONCE_W-1:0]  nonce_last_i,
    input  logic [HASH_W-1:0]   target_i,
    output logic                sha_start_o,
    output logic [HEADER_W-1:0] sha_block_o,
    input  logic                sha_complete_i,
    input  logic [HASH_W-1:0]   sha_hash_i,
    output logic                busy_o,
    output logic                found_o,
    output logic [NONCE_W-1:0]  found_nonce_o,
    output logic [HASH_W-1:0]   found_hash_o,
    output logic                exhausted_o,
    output logic                error_o,
    output logic [31:0]         hashes_o
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

    state_e                      state_reg,       state_next;
    logic [HEADER_W-1:NONCE_W]   header_reg,      header_next;
    logic [NONCE_W-1:0]          nonce_reg,       nonce_next;
    logic [NONCE_W-1:0]          last_reg,        last_next;
    logic [HASH_W-1:0]           target_reg,      target_next;
    logic [HASH_W-1:0]           hash_reg,        hash_next;
    logic [WD_W-1:0]             wd_reg,          wd_next;
    logic [31:0]                 hashes_reg,      hashes_next;
    logic                        found_reg,       found_next;
    logic                        exhausted_reg,   exhausted_next;
    logic                        error_reg,       error_next;
    logic [NONCE_W-1:0]          found_nonce_reg, found_nonce_next;
    logic [HASH_W-1:0]           found_hash_reg,  found_hash_next;

    logic            win;
    logic [WD_W-1:0] wd_inc;

    // The nonce field of the template is replaced on the way out.
    logic unused_nonce_field;
    assign unused_nonce_field = &{1'b0, header_i[NONCE_W-1:0]};

    hash_target_cmp #(
        .REVERSE (HASH_REVERSE)
    ) u_cmp (
        .hash   (hash_reg),
        .target (target_reg),
        .win    (win)
    );

    assign wd_inc = wd_reg + 1'b1;

    // Next-state and job/status update; abort overrides everything, including start.
    always_comb begin
        state_next       = state_reg;
        header_next      = header_reg;
        nonce_next       = nonce_reg;
        last_next        = last_reg;
        target_next      = target_reg;
        hash_next        = hash_reg;
        wd_next          = wd_reg;
        hashes_next      = hashes_reg;
        found_next       = found_reg;
        exhausted_next   = exhausted_reg;
        error_next       = error_reg;
        found_nonce_next = found_nonce_reg;
        found_hash_next  = found_hash_reg;

        if (abort_i) begin
            state_next       = ST_IDLE;
            found_next       = 1'b0;
            exhausted_next   = 1'b0;
            error_next       = 1'b0;
            found_nonce_next = '0;
            found_hash_next  = '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        header_next      = header_i[HEADER_W-1:NONCE_W];
                        nonce_next       = nonce_first_i;
                        last_next        = nonce_last_i;
                        target_next      = target_i;
                        hashes_next      = '0;
                        found_next       = 1'b0;
                        exhausted_next   = 1'b0;
                        error_next       = 1'b0;
                        found_nonce_next = '0;
                        found_hash_next  = '0;
                        // An empty range finishes without touching the engine.
                        if (nonce_first_i > nonce_last_i) begin
                            state_next     = ST_DONE;
                            exhausted_next = 1'b1;
                        end else begin
                            state_next = ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    wd_next    = '0;
                    state_next = ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion is tested first so it beats a coincident timeout.
                    if (sha_complete_i) begin
                        hash_next   = sha_hash_i;
                        hashes_next = hashes_reg + 32'd1;
                        state_next  = ST_CHECK;
                    end else if (wd_inc == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        error_next = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        wd_next = wd_inc;
                    end
                end
                ST_CHECK: begin
                    if (win) begin
                        found_next       = 1'b1;
                        found_nonce_next = nonce_reg;
                        found_hash_next  = hash_reg;
                        state_next       = ST_DONE;
                    end else if (nonce_reg == last_reg) begin
                        // Equality end test: a last nonce of all-ones never wraps to 0.
                        exhausted_next = 1'b1;
                        state_next     = ST_DONE;
                    end else begin
                        nonce_next = nonce_reg + 1'b1;
                        state_next = ST_ISSUE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // State and job registers, cleared by the asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg       <= ST_IDLE;
            header_reg      <= '0;
            nonce_reg       <= '0;
            last_reg        <= '0;
            target_reg      <= '0;
            hash_reg        <= '0;
            wd_reg          <= '0;
            hashes_reg      <= '0;
            found_reg       <= 1'b0;
            exhausted_reg   <= 1'b0;
            error_reg       <= 1'b0;
            found_nonce_reg <= '0;
            found_hash_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            header_reg      <= header_next;
            nonce_reg       <= nonce_next;
            last_reg        <= last_next;
            target_reg      <= target_next;
            hash_reg        <= hash_next;
            wd_reg          <= wd_next;
            hashes_reg      <= hashes_next;
            found_reg       <= found_next;
            exhausted_reg   <= exhausted_next;
            error_reg       <= error_next;
            found_nonce_reg <= found_nonce_next;
            found_hash_reg  <= found_hash_next;
        end
    end

    assign sha_start_o   = (state_reg == ST_ISSUE);
    assign sha_block_o   = {header_reg, byteswap32(nonce_reg)};
    assign busy_o        = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT) ||
                           (state_reg == ST_CHECK);
    assign found_o       = found_reg;
    assign found_nonce_o = found_nonce_reg;
    assign found_hash_o  = found_hash_reg;
    assign exhausted_o   = exhausted_reg;
    assign error_o       = error_reg;
    assign hashes_o      = hashes_reg;

endmodule

// File: tb/tb_nonce_scanner.sv
// Directed bench for nonce_scanner with a fixed-latency doublesha stub.
module tb_nonce_scanner;

    localparam int STUB_L = 5;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic         abort_i;
    logic [639:0] header_i;
    logic [31:0]  nonce_first_i;
    logic [31:0]  nonce_last_i;
    logic [255:0] target_i;
    logic         sha_start_o;
    logic [639:0] sha_block_o;
    logic         sha_complete_i = 1'b0;
    logic [255:0] sha_hash_i = '0;
    logic         busy_o;
    logic         found_o;
    logic [31:0]  found_nonce_o;
    logic [255:0] found_hash_o;
    logic         exhausted_o;
    logic         error_o;
    logic [31:0]  hashes_o;

    int checks = 0;
    int errors = 0;

    // Stub engine state (written only by the stub process).
    int          start_total = 0;
    int          stub_cnt = 0;
    logic        stub_mute = 1'b0;
    logic [31:0] stub_nonce = '0;
    logic [31:0] nonce_log [0:63];

    logic [639:0] hdr_a = {{19{32'h0123_4567}}, 32'hDEAD_BEEF};
    logic [639:0] hdr_b = {{19{32'h89AB_CDEF}}, 32'h1234_5678};
    logic [255:0] ones  = {256{1'b1}};
    logic [255:0] hash7 = {{31{8'hFF}}, 8'h00};
    logic [255:0] tgt7  = {8'h00, {31{8'hFF}}};
    int s0;

    always #5 clk_i = ~clk_i;

    nonce_scanner #(
        .TIMEOUT_CYCLES (16),
        .HASH_REVERSE   (1'b1)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .header_i       (header_i),
        .nonce_first_i  (nonce_first_i),
        .nonce_last_i   (nonce_last_i),
        .target_i       (target_i),
        .sha_start_o    (sha_start_o),
        .sha_block_o    (sha_block_o),
        .sha_complete_i (sha_complete_i),
        .sha_hash_i     (sha_hash_i),
        .busy_o         (busy_o),
        .found_o        (found_o),
        .found_nonce_o  (found_nonce_o),
        .found_hash_o   (found_hash_o),
        .exhausted_o    (exhausted_o),
        .error_o        (error_o),
        .hashes_o       (hashes_o)
    );

    // Stub: completes STUB_L cycles after a start; only nonce 7 gives the special digest.
    always @(posedge clk_i) begin
        sha_complete_i <= 1'b0;
        if (sha_start_o) begin
            logic [31:0] n;
            n = {sha_block_o[7:0], sha_block_o[15:8], sha_block_o[23:16], sha_block_o[31:24]};
            nonce_log[start_total % 64] <= n;
            start_total <= start_total + 1;
            stub_nonce  <= n;
            stub_cnt    <= STUB_L - 1;
            $display("tb: start nonce=%08h", n);
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1 && !stub_mute) begin
                sha_complete_i <= 1'b1;
                sha_hash_i     <= (stub_nonce == 32'd7) ? hash7 : ones;
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [31:0] f, input logic [31:0] l, input logic [255:0] t);
        nonce_first_i = f;
        nonce_last_i  = l;
        target_i      = t;
        start_i       = 1'b1;
        tick();
        start_i       = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy_o && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_bound"}, {639'd0, busy_o}, 640'd0);
    endtask

    initial begin
        rst_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        header_i = hdr_a; nonce_first_i = '0; nonce_last_i = '0; target_i = '0;
        #2;
        chk("rst_busy", {639'd0, busy_o}, 640'd0);
        chk("rst_block", sha_block_o, 640'd0);
        chk("rst_flags", {637'd0, found_o, exhausted_o, error_o}, 640'd0);
        chk("rst_hashes", {608'd0, hashes_o}, 640'd0);
        tick(); tick();
        rst_i = 1'b1;
        tick();

        // Single-nonce win, nonce byte-swapped into the header, input changes ignored.
        s0 = start_total;
        start_job(32'h3bb0cc08, 32'h3bb0cc08, ones);
        chk("win1_start", {639'd0, sha_start_o}, 640'd1);
        chk("win1_nonce_field", {608'd0, sha_block_o[31:0]}, {608'd0, 32'h08ccb03b});
        chk("win1_hdr", {32'd0, sha_block_o[639:32]}, {32'd0, hdr_a[639:32]});
        header_i = hdr_b;
        repeat (6) tick();
        chk("win1_early", {639'd0, found_o}, 640'd0);
        tick();
        chk("win1_found", {639'd0, found_o}, 640'd1);
        chk("win1_nonce", {608'd0, found_nonce_o}, {608'd0, 32'h3bb0cc08});
        chk("win1_hashes", {608'd0, hashes_o}, 640'd1);
        chk("win1_busy", {639'd0, busy_o}, 640'd0);
        chk("win1_starts", 640'(start_total - s0), 640'd1);
        chk("win1_hdr_hold", {32'd0, sha_block_o[639:32]}, {32'd0, hdr_a[639:32]});
        chk("win1_fhash", {384'd0, found_hash_o}, {384'd0, ones});

        // Empty range from DONE: exhausted next cycle, no engine start.
        s0 = start_total;
        start_job(32'd9, 32'd3, 256'd0);
        chk("empty_exh", {638'd0, exhausted_o, found_o}, 640'd2);
        chk("empty_busy", {639'd0, busy_o}, 640'd0);
        repeat (10) tick();
        chk("empty_starts", 640'(start_total - s0), 640'd0);

        // Exhaustion 10..13; late target/start changes must not disturb the job.
        s0 = start_total;
        start_job(32'd10, 32'd13, 256'd0);
        target_i = ones;
        tick(); tick();
        nonce_first_i = 32'd100;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_idle("exh", 200);
        chk("exh_flags", {637'd0, found_o, exhausted_o, error_o}, 640'd2);
        chk("exh_hashes", {608'd0, hashes_o}, 640'd4);
        chk("exh_starts", 640'(start_total - s0), 640'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("exh_log%0d", k), {608'd0, nonce_log[(s0 + k) % 64]}, 640'(10 + k));
        end

        // Range ending at all-ones must not wrap to nonce 0.
        s0 = start_total;
        start_job(32'hFFFFFFFE, 32'hFFFFFFFF, 256'd0);
        wait_idle("wrap", 100);
        chk("wrap_exh", {639'd0, exhausted_o}, 640'd1);
        repeat (20) tick();
        chk("wrap_starts", 640'(start_total - s0), 640'd2);
        chk("wrap_log1", {608'd0, nonce_log[(s0 + 1) % 64]}, {608'd0, 32'hFFFFFFFF});

        // Mid-range win that only exists in byte-reversed order.
        s0 = start_total;
        start_job(32'd5, 32'd20, tgt7);
        wait_idle("rev", 200);
        chk("rev_found", {639'd0, found_o}, 640'd1);
        chk("rev_nonce", {608'd0, found_nonce_o}, 640'd7);
        chk("rev_hashes", {608'd0, hashes_o}, 640'd3);
        chk("rev_fhash", {384'd0, found_hash_o}, {384'd0, hash7});
        chk("rev_starts", 640'(start_total - s0), 640'd3);

        // Engine never answers: error exactly 16 cycles after the ISSUE cycle.
        stub_mute = 1'b1;
        start_job(32'd0, 32'd5, ones);
        repeat (15) tick();
        chk("to_early", {638'd0, error_o, busy_o}, 640'd1);
        tick();
        chk("to_error", {638'd0, error_o, busy_o}, 640'd2);
        chk("to_hashes", {608'd0, hashes_o}, 640'd0);
        stub_mute = 1'b0;
        repeat (8) tick();

        // Abort (with a coincident start) during the second WAIT.
        s0 = start_total;
        start_job(32'd0, 32'd3, 256'd0);
        repeat (9) tick();
        chk("ab_pre", {607'd0, busy_o, hashes_o}, {607'd0, 1'b1, 32'd1});
        abort_i = 1'b1;
        start_i = 1'b1;
        tick();
        abort_i = 1'b0;
        start_i = 1'b0;
        chk("ab_idle", {636'd0, busy_o, found_o, exhausted_o, error_o}, 640'd0);
        chk("ab_hashes", {608'd0, hashes_o}, 640'd1);
        repeat (10) tick();
        chk("ab_late_cmp", {607'd0, busy_o, hashes_o}, 640'd1);
        chk("ab_starts", 640'(start_total - s0), 640'd2);

        // Asynchronous reset while the engine is busy.
        s0 = start_total;
        start_job(32'd0, 32'd3, 256'd0);
        repeat (9) tick();
        rst_i = 1'b0;
        #1;
        chk("rm_outs", {635'd0, busy_o, sha_start_o, found_o, exhausted_o, error_o}, 640'd0);
        chk("rm_block", sha_block_o, 640'd0);
        chk("rm_hashes", {608'd0, hashes_o}, 640'd0);
        tick(); tick();
        rst_i = 1'b1;
        repeat (10) tick();
        chk("rm_after", {607'd0, busy_o, hashes_o}, 640'd0);
        chk("rm_starts", 640'(start_total - s0), 640'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
